// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 job scheduler.
package sha256_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        ACK_WAIT = 2'd2,
        RUN      = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_W        = 16;
    localparam int DEFAULT_START_TIMEOUT = 4;
    localparam int CNT_W                 = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sha256_rr_pick.sv
// Rotating-priority picker: the first pending requester at or after the pointer wins.
module sha256_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   pointer,
    output logic               any,
    output logic [IDX_W-1:0]   grant
);

    logic [IDX_W:0] idx;

    // Walk offsets from farthest to nearest so the nearest pending slot overwrites the rest.
    always_comb begin
        any   = |pending;
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, pointer} + (IDX_W + 1)'(k);
            if (idx >= (IDX_W + 1)'(NUM_REQ)) begin
                idx = idx - (IDX_W + 1)'(NUM_REQ);
            end
            if (pending[idx[IDX_W-1:0]]) begin
                grant = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Shares one SHA-256 core between NUM_REQ requesters: one queued job per requester,
// round-robin grant, core start/done handshake, completion pulses and job latency.
module sha256_job_scheduler
    import sha256_sched_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int ADDR_W        = DEFAULT_ADDR_W,
    parameter  int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_msg_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_out_addr,
    output logic [NUM_REQ-1:0]        cmp_done,
    output logic [NUM_REQ-1:0]        cmp_err,
    output logic                      core_start,
    output logic [ADDR_W-1:0]         core_message_addr,
    output logic [ADDR_W-1:0]         core_output_addr,
    input  logic                      core_done,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic [CNT_W-1:0]          last_cycles,
    output logic                      err_stall
);

    localparam int WAIT_W = $clog2(START_TIMEOUT + 1);

    state_t              state;
    state_t              state_next;
    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  pending_next;
    logic [ADDR_W-1:0]   slot_msg [NUM_REQ];
    logic [ADDR_W-1:0]   slot_out [NUM_REQ];
    logic [IDX_W-1:0]    pointer;
    logic [CNT_W-1:0]    lat_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;
    logic                do_grant;
    logic                job_ok;
    logic                job_fail;
    logic                finish;

    sha256_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .pending (pending),
        .pointer (pointer),
        .any     (pick_any),
        .grant   (pick_idx)
    );

    // Next-state decode; a stuck-high core_done in ACK_WAIT ends the job as a failure.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        job_ok     = 1'b0;
        job_fail   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && core_done) begin
                    state_next = START;
                    do_grant   = 1'b1;
                end
            end
            START: begin
                state_next = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (!core_done) begin
                    state_next = RUN;
                end else if (wait_cnt == WAIT_W'(START_TIMEOUT)) begin
                    job_fail   = 1'b1;
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (core_done) begin
                    job_ok     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        finish = job_ok | job_fail;
    end

    // Completion pulses go to the grantee in the same cycle the job ends.
    always_comb begin
        cmp_done           = '0;
        cmp_err            = '0;
        cmp_done[grant_id] = finish;
        cmp_err[grant_id]  = job_fail;
    end

    // Slot occupancy: accepts set, completion of the grantee clears (a same-cycle valid sees ready=0).
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pending_next[i] = 1'b1;
            end
        end
        if (finish) begin
            pending_next[grant_id] = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending bits, registered ready, and address latching on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            req_ready <= '1;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_msg[i] <= '0;
                slot_out[i] <= '0;
            end
        end else begin
            pending   <= pending_next;
            req_ready <= ~pending_next;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    slot_msg[i] <= req_msg_addr[i*ADDR_W +: ADDR_W];
                    slot_out[i] <= req_out_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Grant capture, core pins, latency/ack counters, pointer advance and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id          <= '0;
            pointer           <= '0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            core_start        <= 1'b0;
            busy              <= 1'b0;
            lat_cnt           <= '0;
            wait_cnt          <= '0;
            last_cycles       <= '0;
            err_stall         <= 1'b0;
        end else begin
            core_start <= (state_next == START);
            busy       <= (state_next != IDLE);
            if (do_grant) begin
                grant_id          <= pick_idx;
                core_message_addr <= slot_msg[pick_idx];
                core_output_addr  <= slot_out[pick_idx];
                lat_cnt           <= CNT_W'(1);
                wait_cnt          <= '0;
            end else if (state != IDLE) begin
                if (lat_cnt != CNT_MAX) begin
                    lat_cnt <= lat_cnt + CNT_W'(1);
                end
                if (state == ACK_WAIT && core_done && !job_fail) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
            if (finish) begin
                pointer <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
            end
            if (job_ok) begin
                last_cycles <= lat_cnt;
            end
            if (job_fail) begin
                err_stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Self-checking bench for sha256_job_scheduler: directed scenarios plus random traffic,
// compared every cycle against a job-level reference model.
module tb_sha256_job_scheduler;

    localparam int NUM_REQ       = 4;
    localparam int ADDR_W        = 16;
    localparam int START_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_msg_addr;
    logic [63:0] req_out_addr;
    logic [3:0]  cmp_done;
    logic [3:0]  cmp_err;
    logic        core_start;
    logic [15:0] core_message_addr;
    logic [15:0] core_output_addr;
    logic        core_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic [31:0] last_cycles;
    logic        err_stall;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state (job level)
    logic [3:0]  m_pend;
    logic [15:0] m_msg [4];
    logic [15:0] m_out [4];
    int          m_ptr;
    bit          m_inflight;
    bit          m_seen_low;
    int          m_age;
    int          m_g;
    logic [15:0] m_cmsg;
    logic [15:0] m_cout;
    logic [31:0] m_last;
    bit          m_stall;
    int          grant_log[$];

    // stimulus and core model
    bit [3:0]    want;
    bit [3:0]    hold;
    bit [3:0]    use_dir;
    bit [3:0]    acc_mask;
    logic [15:0] dir_msg [4];
    logic [15:0] dir_out [4];
    int core_s     = -1000;
    int core_delay = 0;
    int core_run   = 0;
    int next_delay = 2;
    int next_run   = 4;
    int starts_total = 0;
    int done_cnt [4];
    int err_cnt  [4];
    int start_cycle = 0;
    int err_cycle   = 0;

    sha256_job_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .ADDR_W        (ADDR_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_msg_addr      (req_msg_addr),
        .req_out_addr      (req_out_addr),
        .cmp_done          (cmp_done),
        .cmp_err           (cmp_err),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .busy              (busy),
        .grant_id          (grant_id),
        .last_cycles       (last_cycles),
        .err_stall         (err_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic coreLevel();
        if (!reset_n) return 1'b1;
        if (cyc >= core_s + core_delay + 1 && cyc <= core_s + core_delay + core_run) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit modelBusy();
        return (want != 0) || m_inflight || (m_pend != 0);
    endfunction

    task automatic modelReset();
        m_pend     = '0;
        m_ptr      = 0;
        m_inflight = 0;
        m_seen_low = 0;
        m_age      = 0;
        m_g        = 0;
        m_cmsg     = '0;
        m_cout     = '0;
        m_last     = '0;
        m_stall    = 0;
        core_s     = -1000;
        acc_mask   = '0;
        for (int i = 0; i < 4; i++) begin
            m_msg[i] = '0;
            m_out[i] = '0;
        end
    endtask

    task automatic checkReset();
        logic [3:0] e_rdy;
        e_rdy = 4'hF;
        chk("rst_ready",    req_ready, e_rdy);
        chk("rst_start",    core_start, 0);
        chk("rst_cmp_done", cmp_done, 0);
        chk("rst_cmp_err",  cmp_err, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_grant",    grant_id, 0);
        chk("rst_msg",      core_message_addr, 0);
        chk("rst_out",      core_output_addr, 0);
        chk("rst_last",     last_cycles, 0);
        chk("rst_stall",    err_stall, 0);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        want     = want & ~(acc_mask & ~hold);
        acc_mask = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = want[i];
            req_msg_addr[i*16 +: 16] = use_dir[i] ? dir_msg[i] : 16'($urandom);
            req_out_addr[i*16 +: 16] = use_dir[i] ? dir_out[i] : 16'($urandom);
        end
        core_done = coreLevel();
    endtask

    task automatic checkOutput();
        logic [3:0] old_pend;
        logic [3:0] e_rdy;
        logic [3:0] e_done;
        logic [3:0] e_err;
        bit comp;
        bit err;
        bit seen_next;
        int g;
        int idx;
        if (!reset_n) begin
            checkReset();
            modelReset();
            cyc++;
            return;
        end
        old_pend  = m_pend;
        comp      = 0;
        err       = 0;
        seen_next = m_seen_low;
        if (m_inflight && m_age >= 1) begin
            if (!m_seen_low) begin
                if (!core_done) seen_next = 1;
                else if (m_age - 1 == START_TIMEOUT) begin
                    comp = 1;
                    err  = 1;
                end
            end else if (core_done) begin
                comp = 1;
            end
        end
        e_rdy  = ~old_pend;
        e_done = '0;
        e_err  = '0;
        if (comp) e_done[m_g] = 1'b1;
        if (err)  e_err[m_g]  = 1'b1;
        chk("req_ready",   req_ready, e_rdy);
        chk("core_start",  core_start, (m_inflight && m_age == 0) ? 1 : 0);
        chk("busy",        busy, m_inflight ? 1 : 0);
        chk("grant_id",    grant_id, m_g);
        chk("core_msg",    core_message_addr, m_cmsg);
        chk("core_out",    core_output_addr, m_cout);
        chk("last_cycles", last_cycles, m_last);
        chk("err_stall",   err_stall, m_stall ? 1 : 0);
        chk("cmp_done",    cmp_done, e_done);
        chk("cmp_err",     cmp_err, e_err);

        if (core_start === 1'b1) begin
            starts_total++;
            core_s      = cyc;
            core_delay  = next_delay;
            core_run    = next_run;
            start_cycle = cyc;
        end
        for (int i = 0; i < 4; i++) begin
            if (cmp_done[i] === 1'b1) done_cnt[i]++;
            if (cmp_err[i] === 1'b1) begin
                err_cnt[i]++;
                err_cycle = cyc;
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && !old_pend[i]) begin
                m_pend[i]   = 1'b1;
                m_msg[i]    = req_msg_addr[i*16 +: 16];
                m_out[i]    = req_out_addr[i*16 +: 16];
                acc_mask[i] = 1'b1;
            end
        end
        if (m_inflight) begin
            m_age++;
            m_seen_low = seen_next;
            if (comp) begin
                m_pend[m_g] = 1'b0;
                m_ptr       = (m_g + 1) % NUM_REQ;
                m_inflight  = 0;
                if (err) m_stall = 1;
                else     m_last  = 32'(m_age);
            end
        end else if (old_pend != 0 && core_done) begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && old_pend[idx]) g = idx;
            end
            m_g        = g;
            m_inflight = 1;
            m_age      = 0;
            m_seen_low = 0;
            m_cmsg     = m_msg[g];
            m_cout     = m_out[g];
            grant_log.push_back(g);
        end
        cyc++;
    endtask

    task automatic cycle();
        applyStimulus();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (modelBusy() && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (modelBusy()) begin
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles", name, budget);
        end
        cycle();
    endtask

    task automatic waitUntil(input string name, input int budget, input bit need_run);
        int n;
        n = 0;
        while (!(m_inflight && (m_seen_low || !need_run)) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (!(m_inflight && (m_seen_low || !need_run))) begin
            errors++;
            $display("[TB] FAIL %s: job not reached after %0d cycles", name, budget);
        end
    endtask

    initial begin
        int d0;
        int dsum;
        int nsum;
        int order4 [4] = '{0, 1, 2, 3};
        int order3 [3] = '{2, 3, 1};

        reset_n      = 1'b0;
        req_valid    = '0;
        req_msg_addr = '0;
        req_out_addr = '0;
        core_done    = 1'b1;
        want         = '0;
        hold         = '0;
        use_dir      = '0;
        for (int i = 0; i < 4; i++) begin
            done_cnt[i] = 0;
            err_cnt[i]  = 0;
            dir_msg[i]  = '0;
            dir_out[i]  = '0;
        end
        modelReset();
        $display("[TB] reset phase");
        repeat (3) cycle();
        applyStimulus();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput();

        $display("[TB] single job");
        starts_total = 0;
        use_dir[0]   = 1'b1;
        dir_msg[0]   = 16'h0000;
        dir_out[0]   = 16'h0100;
        next_delay   = 3;
        next_run     = 150;
        want[0]      = 1'b1;
        waitIdle("single_job", 400);
        chk("single_latency", last_cycles, 155);
        chk("single_msg", core_message_addr, 16'h0000);
        chk("single_out", core_output_addr, 16'h0100);
        chk("single_starts", starts_total, 1);
        chk("single_done0", done_cnt[0], 1);
        use_dir = '0;

        $display("[TB] all four requesters");
        next_delay = 1;
        next_run   = 3;
        want[3]    = 1'b1;
        waitIdle("ptr_align", 100);
        grant_log.delete();
        want = 4'hF;
        waitIdle("all_four", 200);
        chk("all_four_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) chk("all_four_order", grant_log[k], order4[k]);
        end

        $display("[TB] fairness");
        grant_log.delete();
        want[2] = 1'b1;
        waitUntil("fair_grant2", 50, 0);
        want[1] = 1'b1;
        want[3] = 1'b1;
        waitIdle("fairness", 200);
        chk("fair_count", grant_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < grant_log.size()) chk("fair_order", grant_log[k], order3[k]);
        end

        $display("[TB] ack boundary and stall");
        d0         = err_cnt[2];
        next_delay = START_TIMEOUT;
        next_run   = 3;
        want[2]    = 1'b1;
        waitIdle("ack_boundary", 100);
        chk("ack_boundary_err", err_cnt[2] - d0, 0);
        chk("ack_boundary_last", last_cycles, 9);
        chk("ack_boundary_stall", err_stall, 0);
        next_delay = 1000;
        want[1]    = 1'b1;
        waitIdle("stall", 100);
        chk("stall_errs", err_cnt[1], 1);
        chk("stall_gap", err_cycle - start_cycle, START_TIMEOUT + 1);
        chk("stall_flag", err_stall, 1);
        chk("stall_last_kept", last_cycles, 9);
        d0         = done_cnt[0];
        next_delay = 2;
        next_run   = 4;
        want[0]    = 1'b1;
        waitIdle("after_stall", 100);
        chk("after_stall_done", done_cnt[0] - d0, 1);
        chk("after_stall_flag", err_stall, 1);
        chk("after_stall_last", last_cycles, 8);

        $display("[TB] back-to-back");
        d0         = done_cnt[0];
        next_delay = 0;
        next_run   = 2;
        hold[0]    = 1'b1;
        want[0]    = 1'b1;
        repeat (40) cycle();
        hold = '0;
        waitIdle("b2b", 100);
        chk("b2b_jobs", (done_cnt[0] - d0 >= 3) ? 1 : 0, 1);

        $display("[TB] reset mid-run");
        next_delay = 1;
        next_run   = 50;
        want[2]    = 1'b1;
        waitUntil("reset_wait_run", 100, 1);
        repeat (3) cycle();
        applyStimulus();
        #2;
        reset_n   = 1'b0;
        core_done = 1'b1;
        want      = '0;
        #1;
        checkReset();
        @(negedge clk);
        checkOutput();
        cycle();
        applyStimulus();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput();
        dsum = 0;
        for (int i = 0; i < 4; i++) dsum += done_cnt[i];
        repeat (10) cycle();
        nsum = 0;
        for (int i = 0; i < 4; i++) nsum += done_cnt[i];
        chk("no_done_after_reset", nsum, dsum);
        d0         = done_cnt[1];
        next_delay = 2;
        next_run   = 5;
        want[1]    = 1'b1;
        waitIdle("post_reset_job", 100);
        chk("post_reset_done", done_cnt[1] - d0, 1);
        chk("post_reset_last", last_cycles, 9);

        $display("[TB] random traffic");
        repeat (600) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) want[i] = 1'b1;
            end
            next_delay = $urandom_range(0, 5);
            next_run   = $urandom_range(1, 12);
            cycle();
        end
        waitIdle("random_drain", 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
